// File: rtl/inert_serf_pkg.sv
// inert_pkg: shared constants and types for the inert_serf sensor responder.
// Holds the register address map, the fixed WHO_AM_I value, frame geometry,
// the SPI frame state enum and a saturating-increment helper.
package inert_pkg;

    localparam logic [6:0] ADDR_INT_CTRL = 7'h0D;
    localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
    localparam logic [6:0] ADDR_GYRO_CFG = 7'h11;
    localparam logic [6:0] ADDR_CTRL3    = 7'h14;
    localparam logic [6:0] ADDR_ERR_CNT  = 7'h1E;
    localparam logic [6:0] ADDR_YAW_L    = 7'h26;
    localparam logic [6:0] ADDR_YAW_H    = 7'h27;

    localparam logic [7:0] WHO_AM_I_VAL  = 8'h6A;

    // A well-formed frame carries exactly this many SCLK rises.
    localparam logic [4:0] FRAME_RISES   = 5'd16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Increment an 8-bit counter, holding at 0xFF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/inert_serf_sync.sv
// spi_edge_sync: double-flop synchronizer for SS_n, SCLK and MOSI with a
// third edge-detect flop and registered rise/fall strobes for SS_n and SCLK.
// The level outputs are taken from the edge-detect flop so they line up
// with the strobes in the same clk cycle.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ss_n_in,
    input  logic sclk_in,
    input  logic mosi_in,
    output logic ss_lvl,
    output logic mosi_lvl,
    output logic ss_fall,
    output logic ss_rise,
    output logic sclk_rise,
    output logic sclk_fall
);

    // Bit 2 = SS_n, bit 1 = SCLK, bit 0 = MOSI. SS_n and SCLK idle high.
    localparam logic [2:0] IDLE_LVL = 3'b110;

    logic [2:0] meta_r;
    logic [2:0] sync_r;
    logic [2:0] prev_r;
    logic       ss_fall_r;
    logic       ss_rise_r;
    logic       sclk_rise_r;
    logic       sclk_fall_r;

    // Two synchronizing stages, one history stage and registered edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r      <= IDLE_LVL;
            sync_r      <= IDLE_LVL;
            prev_r      <= IDLE_LVL;
            ss_fall_r   <= 1'b0;
            ss_rise_r   <= 1'b0;
            sclk_rise_r <= 1'b0;
            sclk_fall_r <= 1'b0;
        end else begin
            meta_r      <= {ss_n_in, sclk_in, mosi_in};
            sync_r      <= meta_r;
            prev_r      <= sync_r;
            ss_fall_r   <=  prev_r[2] & ~sync_r[2];
            ss_rise_r   <= ~prev_r[2] &  sync_r[2];
            sclk_rise_r <= ~prev_r[1] &  sync_r[1];
            sclk_fall_r <=  prev_r[1] & ~sync_r[1];
        end
    end

    assign ss_lvl    = prev_r[2];
    assign mosi_lvl  = prev_r[0];
    assign ss_fall   = ss_fall_r;
    assign ss_rise   = ss_rise_r;
    assign sclk_rise = sclk_rise_r;
    assign sclk_fall = sclk_fall_r;

endmodule

// File: rtl/inert_serf.sv
// inert_serf: SPI responder standing in for the inertial sensor. Serves
// 16-bit register read/write frames, samples yaw_in periodically into
// YAW_H:YAW_L and raises INT when a new sample lands.
// Optional build macro: ERR_CNT_EN adds read-only register 0x1E ERR_CNT, a
// saturating count of aborted frames; without it 0x1E reads as unmapped.
module inert_serf
    import inert_pkg::*;
#(
    parameter int unsigned SMPL_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] yaw_in
);

    localparam logic [15:0] SMPL_LAST = 16'(SMPL_CYC - 32'd1);

    logic        ss_lvl_s;
    logic        mosi_s;
    logic        ss_fall_s;
    logic        ss_rise_s;
    logic        sclk_rise_s;
    logic        sclk_fall_s;

    state_t      state_r;
    state_t      state_s;
    logic [4:0]  rise_cnt_r;
    logic [15:0] rx_r;
    logic [7:0]  tx_r;

    logic [7:0]  int_ctrl_r;
    logic [7:0]  gyro_cfg_r;
    logic [7:0]  ctrl3_r;
    logic [7:0]  yaw_l_r;
    logic [7:0]  yaw_h_r;
    logic        int_r;
    logic        int_s;
    logic        pend_r;
    logic        pend_s;
    logic [15:0] smpl_cnt_r;

    logic [7:0]  cmd_s;
    logic [7:0]  rd_data_s;
    logic        frame_ok_s;
    logic        abort_s;
    logic        wr_en_s;
    logic        rd_yawh_s;
    logic        smpl_exp_s;
    logic        smpl_en_s;
    logic        latch_s;

`ifdef ERR_CNT_EN
    logic [7:0]  err_cnt_r;
`endif

    spi_edge_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .ss_n_in   (SS_n),
        .sclk_in   (SCLK),
        .mosi_in   (MOSI),
        .ss_lvl    (ss_lvl_s),
        .mosi_lvl  (mosi_s),
        .ss_fall   (ss_fall_s),
        .ss_rise   (ss_rise_s),
        .sclk_rise (sclk_rise_s),
        .sclk_fall (sclk_fall_s)
    );

    // Command byte as it stands once the 8th rise has shifted in.
    assign cmd_s      = {rx_r[6:0], mosi_s};
    assign wr_en_s    = frame_ok_s & ~rx_r[15];
    assign rd_yawh_s  = frame_ok_s &  rx_r[15] & (rx_r[14:8] == ADDR_YAW_H);
    assign smpl_exp_s = (smpl_cnt_r == SMPL_LAST);
    assign smpl_en_s  = (gyro_cfg_r[7:4] != 4'h0);
    // Samples only land between frames so a frame never sees a torn yaw pair.
    assign latch_s    = pend_r & ss_lvl_s & (state_r == IDLE);

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and commit/abort qualification.
    always_comb begin
        state_s    = state_r;
        frame_ok_s = 1'b0;
        abort_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (ss_fall_s) state_s = SHIFT;
                else           state_s = IDLE;
            end
            SHIFT: begin
                if (ss_rise_s) state_s = COMMIT;
                else           state_s = SHIFT;
            end
            COMMIT: begin
                state_s = IDLE;
                if (rise_cnt_r == FRAME_RISES) frame_ok_s = 1'b1;
                else                           abort_s    = 1'b1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Read data multiplexer for the address carried in the command byte.
    always_comb begin
        rd_data_s = 8'h00;
        case (cmd_s[6:0])
            ADDR_INT_CTRL: rd_data_s = int_ctrl_r;
            ADDR_WHO_AM_I: rd_data_s = WHO_AM_I_VAL;
            ADDR_GYRO_CFG: rd_data_s = gyro_cfg_r;
            ADDR_CTRL3:    rd_data_s = ctrl3_r;
            ADDR_YAW_L:    rd_data_s = yaw_l_r;
            ADDR_YAW_H:    rd_data_s = yaw_h_r;
`ifdef ERR_CNT_EN
            ADDR_ERR_CNT:  rd_data_s = err_cnt_r;
`endif
            default:       rd_data_s = 8'h00;
        endcase
    end

    // Rise counting, rx shift-in and tx load/shift-out for MISO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_cnt_r <= 5'd0;
            rx_r       <= 16'h0000;
            tx_r       <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ss_fall_s) begin
                        rise_cnt_r <= 5'd0;
                        tx_r       <= 8'h00;
                    end
                end
                SHIFT: begin
                    if (sclk_rise_s) begin
                        if (rise_cnt_r != 5'd31) rise_cnt_r <= rise_cnt_r + 5'd1;
                        if (rise_cnt_r < FRAME_RISES) rx_r <= {rx_r[14:0], mosi_s};
                        if (rise_cnt_r == 5'd7) tx_r <= cmd_s[7] ? rd_data_s : 8'h00;
                    end else if (sclk_fall_s && (rise_cnt_r >= 5'd9) && (rise_cnt_r <= 5'd15)) begin
                        tx_r <= {tx_r[6:0], 1'b0};
                    end
                end
                COMMIT: begin
                    tx_r <= 8'h00;
                end
                default: begin
                    tx_r <= 8'h00;
                end
            endcase
        end
    end

    // Writable registers, updated only by a complete write frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_ctrl_r <= 8'h00;
            gyro_cfg_r <= 8'h00;
            ctrl3_r    <= 8'h00;
        end else if (wr_en_s) begin
            case (rx_r[14:8])
                ADDR_INT_CTRL: int_ctrl_r <= rx_r[7:0];
                ADDR_GYRO_CFG: gyro_cfg_r <= rx_r[7:0];
                ADDR_CTRL3:    ctrl3_r    <= rx_r[7:0];
                default:       ctrl3_r    <= ctrl3_r;
            endcase
        end
    end

    // INT next value: a new sample outranks a YAW_H read clearing it.
    always_comb begin
        int_s = int_r;
        if (latch_s && int_ctrl_r[1]) int_s = 1'b1;
        else if (rd_yawh_s)           int_s = 1'b0;
        else                          int_s = int_r;
    end

    // Pending flag: collapses repeated expiries into a single sample.
    always_comb begin
        pend_s = (pend_r & ~latch_s) | (smpl_exp_s & smpl_en_s);
    end

    // Sample timer, pending flag, yaw capture and INT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smpl_cnt_r <= 16'h0000;
            pend_r     <= 1'b0;
            yaw_l_r    <= 8'h00;
            yaw_h_r    <= 8'h00;
            int_r      <= 1'b0;
        end else begin
            smpl_cnt_r <= smpl_exp_s ? 16'h0000 : (smpl_cnt_r + 16'd1);
            pend_r     <= pend_s;
            int_r      <= int_s;
            if (latch_s) begin
                yaw_l_r <= yaw_in[7:0];
                yaw_h_r <= yaw_in[15:8];
            end
        end
    end

`ifdef ERR_CNT_EN
    // Saturating count of frames discarded for a wrong rise count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= 8'h00;
        end else if (abort_s) begin
            err_cnt_r <= sat_inc8(err_cnt_r);
        end
    end
`endif

    assign MISO = tx_r[7];
    assign INT  = int_r;

endmodule

// File: tb/tb_inert_serf.sv
// Bench for inert_serf: a bit-banged SPI master issues frames and queues the
// byte each 16-rise frame should return on MISO; an independent monitor
// watches the SPI pins, assembles MISO across rises 9..16 and compares.
module tb_inert_serf;

    localparam int unsigned SMPL = 512;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        SS_n   = 1'b1;
    logic        SCLK   = 1'b1;
    logic        MOSI   = 1'b0;
    logic        MISO;
    logic        INT;
    logic [15:0] yaw_in = 16'h0000;

    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned cyc;

    typedef struct {
        logic [7:0] val;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    inert_serf #(.SMPL_CYC(SMPL)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO),
        .INT    (INT),
        .yaw_in (yaw_in)
    );

    always #5 clk = ~clk;

    // Cycle count since reset release, same phase as the sample timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame with nr rises; 16-rise frames queue their expected MISO byte.
    task automatic spi_frame(input logic [15:0] word, input int nr, input logic [7:0] expv, input string nm);
        exp_t e;
        idle(12);
        if (nr == 16) begin
            e.val  = expv;
            e.name = nm;
            exp_q.push_back(e);
        end
        SS_n = 1'b0;
        idle(8);
        for (int i = 0; i < nr; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? word[15 - i] : 1'b0;
            idle(8);
            SCLK = 1'b1;
            idle(8);
        end
        SS_n = 1'b1;
        idle(1);
    endtask

    task automatic wait_int(input logic lvl, input int budget, input string nm);
        int k;
        k = 0;
        while ((INT !== lvl) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        check(nm, 16'(INT), 16'(lvl));
    endtask

    // Monitor: rebuild the MISO byte of each frame and check it against the queue.
    initial begin : monitor
        int         nr;
        logic [7:0] cap;
        exp_t       e;
        forever begin
            @(negedge SS_n);
            nr  = 0;
            cap = 8'h00;
            while (SS_n == 1'b0) begin
                @(posedge SCLK or posedge SS_n);
                if (SS_n == 1'b0) begin
                    nr++;
                    if (nr >= 9 && nr <= 16) cap[16 - nr] = MISO;
                end
            end
            if (nr == 16) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: got byte %h with no expectation queued", cap);
                end else begin
                    e = exp_q.pop_front();
                    if (cap !== e.val) begin
                        n_fail++;
                        $display("FAIL %s: MISO byte %h expected %h", e.name, cap, e.val);
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [15:0] w;
        int          k;

        idle(3);
        check("miso_in_rst", 16'(MISO), 16'd0);
        check("int_in_rst",  16'(INT),  16'd0);
        rst_n = 1'b1;
        idle(5);
        check("int_after_rst", 16'(INT), 16'd0);

        spi_frame(16'h8F00, 16, 8'h6A, "rd_whoami");
        spi_frame(16'h8D00, 16, 8'h00, "rd_int_ctrl_rst");
        spi_frame(16'h9E00, 16, 8'h00, "rd_1e_rst");

        // Aborted frames must leave registers untouched.
        spi_frame(16'h0D02, 10, 8'h00, "abort10");
        spi_frame(16'h8D00, 16, 8'h00, "rd_int_ctrl_after_abort");
        spi_frame(16'h1460, 17, 8'h00, "abort17");
        spi_frame(16'h9400, 16, 8'h00, "rd_ctrl3_after_abort");
`ifdef ERR_CNT_EN
        spi_frame(16'h9E00, 16, 8'h02, "rd_err_cnt");
`endif

        // Plain register writes, read-only and unmapped writes ignored.
        spi_frame(16'h1455, 16, 8'h00, "wr_ctrl3");
        spi_frame(16'h9400, 16, 8'h55, "rd_ctrl3");
        spi_frame(16'h0F55, 16, 8'h00, "wr_whoami_ro");
        spi_frame(16'h8F00, 16, 8'h6A, "rd_whoami_after_wr");
        spi_frame(16'h30FF, 16, 8'h00, "wr_unmapped");
        spi_frame(16'hB000, 16, 8'h00, "rd_unmapped_30");

        // Sampling with INT enabled.
        yaw_in = 16'h1234;
        spi_frame(16'h0D02, 16, 8'h00, "wr_int_ctrl");
        spi_frame(16'h9100, 16, 8'h00, "rd_gyro_before_en");
        spi_frame(16'h1160, 16, 8'h00, "wr_gyro_cfg");
        spi_frame(16'h8D00, 16, 8'h02, "rd_int_ctrl");
        wait_int(1'b1, int'(SMPL) + 40, "int_set");
        spi_frame(16'h1100, 16, 8'h00, "wr_gyro_off");
        spi_frame(16'hA600, 16, 8'h34, "rd_yaw_l");
        check("int_held_after_yaw_l", 16'(INT), 16'd1);
        spi_frame(16'hA700, 16, 8'h12, "rd_yaw_h");
        check("int_at_ss_rise", 16'(INT), 16'd1);
        idle(8);
        check("int_cleared", 16'(INT), 16'd0);

        // Expiry while SS_n is held low: latch waits for the frame to end.
        yaw_in = 16'hBEEF;
        k = 0;
        while (((cyc % SMPL) != 40) && (k < 2 * int'(SMPL))) begin
            @(negedge clk);
            k++;
        end
        spi_frame(16'h1160, 16, 8'h00, "wr_gyro_on");
        SS_n = 1'b0;
        idle(400);
        check("int_during_hold", 16'(INT), 16'd0);
        SS_n = 1'b1;
        wait_int(1'b1, 12, "int_after_hold");
        spi_frame(16'hA600, 16, 8'hEF, "rd_yaw_l_hold");
        spi_frame(16'h0D00, 16, 8'h00, "wr_int_off");
        spi_frame(16'hA700, 16, 8'hBE, "rd_yaw_h_hold");
        idle(8);
        check("int_cleared_2", 16'(INT), 16'd0);

        // Sampling with INT disabled: data updates, INT stays low.
        yaw_in = 16'h5A3C;
        idle(int'(SMPL) + 40);
        check("int_stays_low", 16'(INT), 16'd0);
        spi_frame(16'hA600, 16, 8'h3C, "rd_yaw_l_noint");
        spi_frame(16'hA700, 16, 8'h5A, "rd_yaw_h_noint");
        check("int_still_low", 16'(INT), 16'd0);

        // Reset in the middle of a CTRL3 read.
        spi_frame(16'h145A, 16, 8'h00, "wr_ctrl3_5a");
        spi_frame(16'h0D02, 16, 8'h00, "wr_int_on");
        wait_int(1'b1, int'(SMPL) + 40, "int_before_rst");
        w = 16'h9400;
        idle(12);
        SS_n = 1'b0;
        idle(8);
        for (int i = 0; i < 12; i++) begin
            SCLK = 1'b0;
            MOSI = w[15 - i];
            idle(8);
            SCLK = 1'b1;
            if (i < 11) idle(8);
        end
        idle(2);
        check("miso_pre_rst", 16'(MISO), 16'd1);
        rst_n = 1'b0;
        idle(1);
        check("miso_mid_rst", 16'(MISO), 16'd0);
        check("int_mid_rst",  16'(INT),  16'd0);
        idle(3);
        rst_n = 1'b1;
        idle(4);
        SS_n = 1'b1;
        idle(1);
        spi_frame(16'h9100, 16, 8'h00, "rd_gyro_after_rst");
        spi_frame(16'h9400, 16, 8'h00, "rd_ctrl3_after_rst");
        spi_frame(16'h8D00, 16, 8'h00, "rd_int_ctrl_after_rst");
        spi_frame(16'h8F00, 16, 8'h6A, "rd_whoami_after_rst");
        check("int_after_mid_rst", 16'(INT), 16'd0);

        idle(20);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
